// File: rtl/fetch_queue_pkg.sv
// Shared front-end definitions: fetch FSM states, datapath widths and the queue entry layout.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;

  localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue boundary: redirect input, instruction-memory handshake and decode handshake.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  import cpu_pkg::*;

  logic                   redirect_valid;
  logic [ADDR_W-1:0]      redirect_pc;

  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [ADDR_W-1:0]      imem_req_addr;
  logic                   imem_rsp_valid;
  logic [INSTR_W-1:0]     imem_rsp_data;

  logic                   dec_valid;
  logic                   dec_ready;
  logic [INSTR_W-1:0]     dec_instr;
  logic [ADDR_W-1:0]      dec_pc;
  logic [$clog2(DEPTH):0] fq_count;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  dec_ready,
    output imem_req_valid, imem_req_addr,
    output dec_valid, dec_instr, dec_pc, fq_count
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output dec_ready,
    input  imem_req_valid, imem_req_addr,
    input  dec_valid, dec_instr, dec_pc, fq_count
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Instruction queue storage: circular buffer with push, pop, flush and occupancy count.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: single-outstanding fetch FSM and PC feeding a decode queue.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master fq
);

  fetch_state_e      state;
  fetch_state_e      state_n;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] pend_addr_n;
  logic              req_hs;
  logic              push;
  logic              flush;
  logic              full;
  fetch_entry_t      wentry;
  fetch_entry_t      head;

  assign fq.imem_req_valid = rst && (state == REQ) && !full;
  assign fq.imem_req_addr  = pc;
  assign req_hs            = fq.imem_req_valid && fq.imem_req_ready;

  assign fq.dec_valid = (fq.fq_count != '0);
  assign fq.dec_instr = head.instr;
  assign fq.dec_pc    = head.pc;

  assign wentry.pc    = pend_addr;
  assign wentry.instr = fq.imem_rsp_data;

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    pend_addr_n = pend_addr;
    push        = 1'b0;
    flush       = 1'b0;

    case (state)
      REQ: begin
        if (req_hs) begin
          state_n     = WAIT;
          pc_n        = pc + PC_INC;
          pend_addr_n = pc;
        end
      end
      WAIT: begin
        if (fq.imem_rsp_valid) begin
          push    = 1'b1;
          state_n = REQ;
        end
      end
      DISCARD: begin
        if (fq.imem_rsp_valid) state_n = REQ;
      end
      default: state_n = REQ;
    endcase

    // Any state other than REQ after the normal update means a request is still in flight.
    if (fq.redirect_valid) begin
      push    = 1'b0;
      flush   = 1'b1;
      pc_n    = fq.redirect_pc;
      state_n = (state_n == REQ) ? REQ : DISCARD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      pend_addr <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      pend_addr <= pend_addr_n;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (fq.dec_ready),
    .flush (flush),
    .wdata (wentry),
    .rdata (head),
    .count (fq.fq_count),
    .full  (full)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue with a transaction-level reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst;

  fetch_queue_if #(.DEPTH(DEPTH)) f ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fq  (f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  exp_t        exp_q[$];
  logic [63:0] m_pc       = RESET_PC;
  bit          m_out      = 1'b0;
  bit          m_cancel   = 1'b0;
  logic [63:0] m_out_addr = '0;

  logic [63:0] hs_log[$];
  logic [63:0] pop_log[$];
  int unsigned hs_cnt = 0;
  bit          hs_evt = 1'b0;

  int unsigned p_dec = 100, p_req = 100, p_redir = 0;
  int unsigned lat_min = 1, lat_max = 1;
  bit          mem_busy = 1'b0;
  int          mem_wait = 0;
  bit          stray_rsp = 1'b0;
  bit          force_redir = 1'b0;
  logic [63:0] force_pc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated at the falling edge for what happens at the next rising edge.
  always @(negedge clk) begin : monitor
    bit   exp_rv;
    bit   pop;
    exp_t e;
    if (!rst) begin
      check("reset_req_valid", 64'(f.imem_req_valid), 64'(0));
      check("reset_dec_valid", 64'(f.dec_valid), 64'(0));
      check("reset_fq_count", 64'(f.fq_count), 64'(0));
      exp_q.delete();
      m_pc     = RESET_PC;
      m_out    = 1'b0;
      m_cancel = 1'b0;
    end else begin
      exp_rv = !m_out && (exp_q.size() < DEPTH);
      check("req_valid", 64'(f.imem_req_valid), 64'(exp_rv));
      if (exp_rv) check("req_addr", f.imem_req_addr, m_pc);
      check("fq_count", 64'(f.fq_count), 64'(exp_q.size()));
      check("dec_valid", 64'(f.dec_valid), 64'(exp_q.size() != 0));

      pop = f.dec_ready && (exp_q.size() != 0);
      if (pop) begin
        check("dec_pc", f.dec_pc, exp_q[0].pc);
        check("dec_instr", 64'(f.dec_instr), 64'(exp_q[0].instr));
        pop_log.push_back(exp_q[0].pc);
        void'(exp_q.pop_front());
      end

      if (f.imem_rsp_valid && m_out) begin
        if (!m_cancel && !f.redirect_valid) begin
          e.pc    = m_out_addr;
          e.instr = f.imem_rsp_data;
          exp_q.push_back(e);
        end
        m_out = 1'b0;
      end

      if (f.imem_req_valid && f.imem_req_ready) begin
        hs_log.push_back(f.imem_req_addr);
        hs_cnt++;
        hs_evt = 1'b1;
      end
      if (exp_rv && f.imem_req_ready) begin
        m_out      = 1'b1;
        m_cancel   = 1'b0;
        m_out_addr = m_pc;
        m_pc       = m_pc + 64'd4;
      end

      if (f.redirect_valid) begin
        exp_q.delete();
        m_pc = f.redirect_pc;
        if (m_out) m_cancel = 1'b1;
      end
    end
  end

  task automatic apply_inputs();
    logic [63:0] rpc;
    if (hs_evt) begin
      hs_evt   = 1'b0;
      mem_busy = 1'b1;
      mem_wait = int'($urandom_range(lat_max, lat_min));
    end
    f.imem_rsp_valid = 1'b0;
    if (stray_rsp) begin
      f.imem_rsp_valid = 1'b1;
      f.imem_rsp_data  = $urandom;
      stray_rsp        = 1'b0;
    end else if (mem_busy) begin
      mem_wait--;
      if (mem_wait == 0) begin
        f.imem_rsp_valid = 1'b1;
        f.imem_rsp_data  = $urandom;
        mem_busy         = 1'b0;
      end
    end
    f.dec_ready      = ($urandom_range(99, 0) < p_dec);
    f.imem_req_ready = ($urandom_range(99, 0) < p_req);
    f.redirect_valid = 1'b0;
    if (force_redir) begin
      f.redirect_valid = 1'b1;
      f.redirect_pc    = force_pc;
      force_redir      = 1'b0;
    end else if ($urandom_range(99, 0) < p_redir) begin
      rpc              = {$urandom, $urandom};
      f.redirect_valid = 1'b1;
      f.redirect_pc    = rpc & ~64'h3;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
    apply_inputs();
  endtask

  task automatic drain(input int unsigned n);
    p_dec = 100; p_req = 0; p_redir = 0;
    repeat (n) cycle();
  endtask

  initial begin
    int unsigned h0;
    int unsigned n0;
    logic [63:0] a0;

    rst              = 1'b0;
    f.redirect_valid = 1'b0;
    f.redirect_pc    = '0;
    f.imem_req_ready = 1'b0;
    f.imem_rsp_valid = 1'b0;
    f.imem_rsp_data  = '0;
    f.dec_ready      = 1'b0;
    repeat (3) @(posedge clk);

    // Reset release, 1-cycle memory, decode always ready.
    p_dec = 100; p_req = 100; p_redir = 0; lat_min = 1; lat_max = 1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    apply_inputs();
    repeat (9) cycle();
    check("first_req_addr", hs_log[0], RESET_PC);
    check("pops_seen", 64'(pop_log.size() >= 3), 64'(1));
    if (pop_log.size() >= 3) begin
      check("dec_pc_0", pop_log[0], 64'h0);
      check("dec_pc_1", pop_log[1], 64'h4);
      check("dec_pc_2", pop_log[2], 64'h8);
    end
    h0 = hs_cnt;
    repeat (20) cycle();
    check("throughput_20cyc", 64'(hs_cnt - h0), 64'd10);

    // Decode stalled: queue fills to DEPTH, requests stop until a pop.
    drain(6);
    p_dec = 0; p_req = 100;
    h0 = hs_cnt;
    repeat (20) cycle();
    #1;
    check("full_hs_count", 64'(hs_cnt - h0), 64'(DEPTH));
    check("full_fq_count", 64'(f.fq_count), 64'(DEPTH));
    check("full_req_valid", 64'(f.imem_req_valid), 64'(0));
    p_dec = 100;
    cycle();
    #1;
    check("full_req_held", 64'(f.imem_req_valid), 64'(0));
    p_dec = 0;
    cycle();
    #1;
    check("req_after_pop", 64'(f.imem_req_valid), 64'(1));

    // Redirect while a 3-cycle request is outstanding.
    drain(6);
    p_dec = 100; p_req = 100; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10 && !mem_busy; i++) cycle();
    check("wait_entered", 64'(mem_busy), 64'(1));
    force_redir = 1'b1;
    force_pc    = 64'h100;
    n0          = hs_log.size();
    cycle();
    cycle();
    #1;
    check("redirect_fq_count", 64'(f.fq_count), 64'(0));
    for (int i = 0; i < 20 && hs_log.size() <= n0; i++) cycle();
    check("redirect_hs_seen", 64'(hs_log.size() > n0), 64'(1));
    if (hs_log.size() > n0) check("redirect_addr", hs_log[n0], 64'h100);

    // Memory back-pressure: address stable, PC held.
    lat_min = 1; lat_max = 1;
    drain(8);
    #1;
    a0 = m_pc;
    h0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      cycle();
      #1;
      check("stall_addr", f.imem_req_addr, a0);
      check("stall_valid", 64'(f.imem_req_valid), 64'(1));
    end
    check("stall_no_hs", 64'(hs_cnt - h0), 64'(0));
    p_req = 100;
    n0 = hs_log.size();
    for (int i = 0; i < 5 && hs_log.size() <= n0; i++) cycle();
    if (hs_log.size() > n0) check("stall_release_addr", hs_log[n0], a0);
    else check("stall_release_hs", 64'(0), 64'(1));

    // PC wrap at the top of the address space.
    p_req = 0;
    repeat (3) cycle();
    force_redir = 1'b1;
    force_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    n0 = hs_log.size();
    p_req = 100;
    for (int i = 0; i < 30 && hs_log.size() < n0 + 2; i++) cycle();
    if (hs_log.size() >= n0 + 2) begin
      check("wrap_addr_0", hs_log[n0], 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_addr_1", hs_log[n0+1], 64'h0);
    end else begin
      check("wrap_hs_seen", 64'(hs_log.size() - n0), 64'd2);
    end

    // Asynchronous reset while waiting for a response; stray response afterwards.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10 && !mem_busy; i++) cycle();
    cycle();
    #1;
    rst = 1'b0;
    #1;
    check("async_req_valid", 64'(f.imem_req_valid), 64'(0));
    check("async_dec_valid", 64'(f.dec_valid), 64'(0));
    check("async_fq_count", 64'(f.fq_count), 64'(0));
    mem_busy = 1'b0;
    hs_evt   = 1'b0;
    p_req    = 0;
    cycle();
    @(posedge clk);
    #2;
    rst       = 1'b1;
    stray_rsp = 1'b1;
    apply_inputs();
    p_req = 100;
    n0 = hs_log.size();
    for (int i = 0; i < 10 && hs_log.size() <= n0; i++) cycle();
    if (hs_log.size() > n0) check("post_reset_addr", hs_log[n0], RESET_PC);
    else check("post_reset_hs", 64'(0), 64'(1));

    // Randomized traffic with redirects and variable latency.
    for (int blk = 0; blk < 15; blk++) begin
      p_dec   = $urandom_range(100, 20);
      p_req   = $urandom_range(100, 30);
      p_redir = $urandom_range(8, 0);
      lat_min = 1;
      lat_max = $urandom_range(4, 1);
      repeat (200) cycle();
    end
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 64'h0, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-006 SHALL have port redirect_pc  input  64  redirect target address.
REQ-007 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-008 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-009 SHALL have port imem_req_addr  output  64  fetch byte address.
REQ-010 SHALL have port imem_rsp_valid  input  1  instruction word returned.
REQ-011 SHALL have port imem_rsp_data  input  32  returned instruction.
REQ-012 SHALL have port dec_valid  output  1  queue head valid toward decode.
REQ-013 SHALL have port dec_ready  input  1  decode consumes head.
REQ-014 SHALL have port dec_instr  output  32  head instruction.
REQ-015 SHALL have port dec_pc  output  64  address of head instruction.
REQ-016 SHALL have port fq_count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-017 SHALL hold fetch PC register; advance by 4 on each request handshake (imem_req_valid & imem_req_ready), wrapping mod 2^64.
REQ-018 SHALL allow at most one outstanding request; FSM states REQ (drive req), WAIT (await rsp), DISCARD (await rsp to drop).
REQ-019 SHALL, in REQ, assert imem_req_valid only when fq_count + 0 < DEPTH; REQ -> WAIT on handshake; imem_req_addr = fetch PC, stable while valid and not ready.
REQ-020 SHALL, in WAIT on imem_rsp_valid, write {addr, imem_rsp_data} at tail and go to REQ; entry visible at dec_valid next cycle (one-cycle response-to-decode latency).
REQ-021 SHALL issue next request no earlier than the cycle after the response; steady-state throughput with one-cycle memory is one instruction per two cycles.
REQ-022 SHALL present head combinationally from storage: dec_valid = (fq_count != 0); pop on dec_valid & dec_ready.
REQ-023 SHALL support simultaneous push and pop; fq_count unchanged; at full, push cannot occur by construction (REQ-019).
REQ-024 SHALL ignore dec_ready when empty; read/write pointers wrap mod DEPTH.
REQ-025 SHALL, on redirect_valid, next cycle: fq_count = 0, fetch PC = redirect_pc, state REQ if no request outstanding else DISCARD.
REQ-026 SHALL honour a decode pop in the redirect cycle as a completed handshake; remaining entries flushed.
REQ-027 SHALL, when redirect_valid and imem_rsp_valid coincide, drop the response and go to REQ.
REQ-028 SHALL, in DISCARD, drop the arriving response and go to REQ; a further redirect in DISCARD updates fetch PC, state stays DISCARD.
REQ-029 SHALL, when redirect coincides with a REQ-state handshake, treat the request as outstanding (go to DISCARD) and load redirect_pc.

Reset
REQ-030 SHALL, while rst = 0: fetch PC = RESET_PC, state REQ, pointers and fq_count = 0, dec_valid = 0, imem_req_valid = 0.
REQ-031 SHALL assert imem_req_valid with imem_req_addr = RESET_PC in first cycle after rst rises.
REQ-032 SHALL drop any outstanding response on reset mid-operation; responses arriving before first post-reset handshake ignored.
REQ-033 SHALL not reset queue data storage; only control state.

Structure
REQ-034 SHALL place state enum (REQ/WAIT/DISCARD), instruction width 32, address width 64, PC increment 4 in shared package cpu_pkg.
REQ-035 SHALL implement storage/pointers as sub-module fetch_fifo (push, pop, flush, count); FSM and PC in fetch_queue.

Verification
REQ-036 SHALL test reset release, 1-cycle memory, dec_ready=1 -> requests at 0x0,0x4,0x8; dec_pc sequence 0x0,0x4,0x8 with matching instrs.
REQ-037 SHALL test dec_ready=0 with DEPTH=4 -> exactly 4 requests, fq_count=4, imem_req_valid held 0 until first pop.
REQ-038 SHALL test redirect to 0x100 during WAIT -> pending response dropped, next request addr 0x100, fq_count=0.
REQ-039 SHALL test imem_req_ready=0 for 5 cycles -> imem_req_addr stable, PC not advanced.
REQ-040 SHALL test rst asserted mid-WAIT -> outputs reset asynchronously; after release first addr = RESET_PC; late response ignored.
REQ-041 SHALL test fetch PC at 64'hFFFF_FFFF_FFFF_FFFC -> next request address 0x0.
